// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joysticks into active-low cabinet controls
// with rotation, per-player autofire and a coin pulse generator with lockout.
module arcade_input_mapper #(
  parameter int          PLAYERS  = 2,
  parameter int          BUTTONS  = 3,
  parameter logic [23:0] COIN_LEN = 24'd2457600,
  parameter logic [19:0] AF_DIV   = 20'd409600
) (
  input  logic                         clk_sys,
  input  logic                         I_RESETn,
  input  logic [10:0]                  ps2_key,
  input  logic [16*PLAYERS-1:0]        joystick,
  input  logic [1:0]                   rotate,
  input  logic                         coin_mode,
  input  logic [PLAYERS-1:0]           autofire_en,
  output logic [4*PLAYERS-1:0]         O_DIR_n,
  output logic [BUTTONS*PLAYERS-1:0]   O_BTN_n,
  output logic [PLAYERS-1:0]           O_START_n,
  output logic                         O_COIN_n
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_t;
  coin_t                       state;
  logic [23:0]                 coin_cnt;
  logic                        old_tog, primed, ev, st, key_coin, af_phase, req, req_q;
  logic [8:0]                  code;
  logic [3:0]                  key_dir, dir_hit;
  logic [BUTTONS-1:0]          key_btn, btn_hit;
  logic [PLAYERS-1:0]          key_start, start_hit, start_eff, coin_raw;
  logic [19:0]                 af_cnt;
  logic [4*PLAYERS-1:0]        dir_eff;
  logic [BUTTONS*PLAYERS-1:0]  btn_eff;
  always_comb begin
    ev      = primed && (ps2_key[10] != old_tog);
    st      = ps2_key[9];
    code    = ps2_key[8:0];
    dir_hit = {code[7:0] == 8'h75, code[7:0] == 8'h72, code[7:0] == 8'h6B, code[7:0] == 8'h74};
    for (int b = 0; b < BUTTONS; b++)
      btn_hit[b] = (b == 0) ? (code == 9'h029 || code == 9'h014) :
                   (b == 1) ? (code == 9'h011) :
                   (b == 2) ? (code == 9'h012) : 1'b0;
    for (int p = 0; p < PLAYERS; p++)
      start_hit[p] = (p == 0) ? (code == 9'h005) : (p == 1) ? (code == 9'h006) : 1'b0;
  end
  for (genvar p = 0; p < PLAYERS; p++) begin : g_p
    logic [15:0] j;
    logic [3:0]  raw;
    logic        unused_j;
    assign j        = joystick[16*p +: 16];
    assign unused_j = ^j[15:6+BUTTONS];
    assign raw      = j[3:0] | ((p == 0) ? key_dir : 4'b0);
    // bit order is R,L,D,U; each mode picks which raw direction feeds U',D',L',R'
    assign dir_eff[4*p +: 4] = (rotate == 2'd1) ? {raw[1], raw[0], raw[2], raw[3]} :
                               (rotate == 2'd2) ? {raw[2], raw[3], raw[0], raw[1]} :
                               (rotate == 2'd3) ? {raw[0], raw[1], raw[3], raw[2]} : raw;
    for (genvar b = 0; b < BUTTONS; b++) begin : g_b
      assign btn_eff[BUTTONS*p+b] = (j[4+b] | ((p == 0) & key_btn[b])) &
                                    ((b != 0) | ~autofire_en[p] | af_phase);
    end
    assign start_eff[p] = j[4+BUTTONS] | key_start[p];
    assign coin_raw[p]  = j[5+BUTTONS];
  end
  assign req = (|coin_raw) | key_coin | (~coin_mode & (|start_eff));
  always_ff @(posedge clk_sys or negedge I_RESETn) begin
    if (!I_RESETn) begin
      old_tog   <= 1'b0;
      primed    <= 1'b0;
      key_dir   <= '0;
      key_btn   <= '0;
      key_start <= '0;
      key_coin  <= 1'b0;
      af_cnt    <= '0;
      af_phase  <= 1'b1;
      req_q     <= 1'b0;
      state     <= IDLE;
      coin_cnt  <= '0;
      O_DIR_n   <= '1;
      O_BTN_n   <= '1;
      O_START_n <= '1;
      O_COIN_n  <= 1'b1;
    end else begin
      if (!primed) begin
        old_tog <= ps2_key[10];
        primed  <= 1'b1;
      end else if (ev) begin
        old_tog <= ps2_key[10];
        for (int i = 0; i < 4; i++) if (dir_hit[i]) key_dir[i] <= st;
        for (int b = 0; b < BUTTONS; b++) if (btn_hit[b]) key_btn[b] <= st;
        for (int p = 0; p < PLAYERS; p++) if (start_hit[p]) key_start[p] <= st;
        if (code == 9'h02E) key_coin <= st;
      end
      af_cnt    <= (af_cnt == AF_DIV - 20'd1) ? 20'd0 : af_cnt + 20'd1;
      af_phase  <= (af_cnt == AF_DIV - 20'd1) ? ~af_phase : af_phase;
      O_DIR_n   <= ~dir_eff;
      O_BTN_n   <= ~btn_eff;
      O_START_n <= ~start_eff;
      req_q     <= req;
      // only a fresh rising edge seen in IDLE starts a pulse; edges while busy are lost
      case (state)
        IDLE: if (req && !req_q) begin
          state    <= PULSE;
          coin_cnt <= '0;
          O_COIN_n <= 1'b0;
        end
        PULSE: if (coin_cnt == COIN_LEN - 24'd1) begin
          state    <= GAP;
          coin_cnt <= '0;
          O_COIN_n <= 1'b1;
        end else coin_cnt <= coin_cnt + 24'd1;
        GAP: if (coin_cnt == COIN_LEN - 24'd1) begin
          state    <= IDLE;
          coin_cnt <= '0;
        end else coin_cnt <= coin_cnt + 24'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: random and directed stimulus, scoreboard queue checked by a monitor.
module tb_arcade_input_mapper;
  localparam int P = 2, B = 3, CL = 20, AFD = 4;
  logic         clk_sys = 1'b0, I_RESETn = 1'b0, coin_mode = 1'b0;
  logic [10:0]  ps2_key = 11'h400;
  logic [31:0]  joystick = '0;
  logic [1:0]   rotate = '0, autofire_en = '0;
  logic [7:0]   O_DIR_n;
  logic [5:0]   O_BTN_n;
  logic [1:0]   O_START_n;
  logic         O_COIN_n;
  arcade_input_mapper #(.PLAYERS(P), .BUTTONS(B), .COIN_LEN(24'(CL)), .AF_DIV(20'(AFD))) dut (
    .clk_sys(clk_sys), .I_RESETn(I_RESETn), .ps2_key(ps2_key), .joystick(joystick),
    .rotate(rotate), .coin_mode(coin_mode), .autofire_en(autofire_en),
    .O_DIR_n(O_DIR_n), .O_BTN_n(O_BTN_n), .O_START_n(O_START_n), .O_COIN_n(O_COIN_n));
  always #5 clk_sys = ~clk_sys;
  typedef struct packed { logic [7:0] dir; logic [5:0] btn; logic [1:0] start; logic coin; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  // model state: held keyboard functions, last seen toggle, coin timing by absolute cycle
  int n, pulse_at, free_at;
  logic m_tog, k_coin, prev_req;
  logic [3:0] k_dir;
  logic [2:0] k_btn;
  logic [1:0] k_start;
  logic [8:0] codes [16] = '{9'h175, 9'h075, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h029,
                             9'h014, 9'h011, 9'h012, 9'h005, 9'h006, 9'h02E, 9'h01C, 9'h15A};
  // bit position of the compass directions R, U, L, D (counter-clockwise quarter turns)
  int pos [4] = '{0, 3, 1, 2};
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    n = 0; k_dir = '0; k_btn = '0; k_start = '0; k_coin = 1'b0;
    prev_req = 1'b0; pulse_at = -1000000; free_at = 0; m_tog = 1'b0;
  endtask
  task automatic step(input logic [31:0] joy, input logic [1:0] rot, input logic cm,
                      input logic [1:0] af, input bit kev, input logic kp, input logic [8:0] kc);
    exp_t e;
    logic [3:0] raw;
    logic phase, req, any_start;
    @(negedge clk_sys);
    joystick = joy; rotate = rot; coin_mode = cm; autofire_en = af;
    if (kev) ps2_key = {~ps2_key[10], kp, kc};
    n++;
    phase = (((n - 1) / AFD) % 2) == 0;
    any_start = 1'b0;
    req = k_coin;
    for (int p = 0; p < P; p++) begin
      raw = joy[16*p +: 4] | (p == 0 ? k_dir : 4'b0);
      for (int a = 0; a < 4; a++) e.dir[4*p + pos[a]] = ~raw[pos[(a + rot) % 4]];
      for (int b = 0; b < B; b++)
        e.btn[B*p + b] = ~((joy[16*p+4+b] | (p == 0 && k_btn[b])) && !(b == 0 && af[p] && !phase));
      e.start[p] = ~(joy[16*p+7] | k_start[p]);
      any_start |= ~e.start[p];
      req |= joy[16*p+8];
    end
    if (!cm) req |= any_start;
    if (req && !prev_req && n >= free_at) begin
      pulse_at = n;
      free_at = n + 2*CL + 1;
    end
    prev_req = req;
    e.coin = !(n >= pulse_at && n < pulse_at + CL);
    q.push_back(e);
    if (n == 1) m_tog = ps2_key[10];
    else if (ps2_key[10] != m_tog) begin
      m_tog = ps2_key[10];
      case (ps2_key[7:0])
        8'h75: k_dir[3] = ps2_key[9];
        8'h72: k_dir[2] = ps2_key[9];
        8'h6B: k_dir[1] = ps2_key[9];
        8'h74: k_dir[0] = ps2_key[9];
        default: ;
      endcase
      case (ps2_key[8:0])
        9'h029, 9'h014: k_btn[0] = ps2_key[9];
        9'h011: k_btn[1] = ps2_key[9];
        9'h012: k_btn[2] = ps2_key[9];
        9'h005: k_start[0] = ps2_key[9];
        9'h006: k_start[1] = ps2_key[9];
        9'h02E: k_coin = ps2_key[9];
        default: ;
      endcase
    end
  endtask
  task automatic idle(input int cycles, input logic [31:0] joy, input logic cm, input logic [1:0] af);
    for (int i = 0; i < cycles; i++) step(joy, 2'd0, cm, af, 1'b0, 1'b0, 9'h0);
  endtask
  task automatic do_reset();
    @(negedge clk_sys);
    #2 I_RESETn = 1'b0;
    #1;
    chk("rst_coin", 32'(O_COIN_n), 32'h1);
    chk("rst_dir", 32'(O_DIR_n), 32'hFF);
    chk("rst_btn", 32'(O_BTN_n), 32'h3F);
    chk("rst_start", 32'(O_START_n), 32'h3);
    joystick = '0; autofire_en = '0; rotate = '0; coin_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_sys);
    @(posedge clk_sys);
    #2 I_RESETn = 1'b1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_sys);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dir", 32'(O_DIR_n), 32'(e.dir));
        chk("btn", 32'(O_BTN_n), 32'(e.btn));
        chk("start", 32'(O_START_n), 32'(e.start));
        chk("coin", 32'(O_COIN_n), 32'(e.coin));
      end
    end
  end
  initial begin
    logic [31:0] joy;
    logic [1:0] rot, af;
    logic cm;
    do_reset();
    idle(6, 32'h0, 1'b0, 2'b00);
    step(0, 2'd0, 1'b0, 2'b00, 1'b1, 1'b1, 9'h175);
    idle(3, 32'h0, 1'b0, 2'b00);
    step(0, 2'd0, 1'b0, 2'b00, 1'b1, 1'b0, 9'h175);
    step(0, 2'd1, 1'b0, 2'b00, 1'b1, 1'b1, 9'h175);
    for (int i = 0; i < 3; i++) step(0, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0, 9'h0);
    step(0, 2'd1, 1'b0, 2'b00, 1'b1, 1'b0, 9'h175);
    idle(2, 32'h0, 1'b0, 2'b00);
    idle(3, 32'h0080_0000 >> 0 | 32'h0080_0000, 1'b0, 2'b00);
    idle(CL + 7, 32'h0, 1'b0, 2'b00);
    idle(3, 32'h0080_0000, 1'b0, 2'b00);
    idle(CL + 5, 32'h0, 1'b0, 2'b00);
    idle(4, 32'h0080_0000, 1'b0, 2'b00);
    idle(2*CL + 4, 32'h0, 1'b0, 2'b00);
    idle(4, 32'h0080_0000, 1'b1, 2'b00);
    step(0, 2'd0, 1'b1, 2'b00, 1'b1, 1'b1, 9'h02E);
    step(0, 2'd0, 1'b1, 2'b00, 1'b1, 1'b0, 9'h02E);
    idle(2*CL + 4, 32'h0, 1'b1, 2'b00);
    idle(20, 32'h0000_0010, 1'b0, 2'b01);
    idle(6, 32'h0000_0010, 1'b0, 2'b00);
    joy = '0; rot = '0; cm = 1'b0; af = '0;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < P; p++)
        for (int k = 0; k < 9; k++)
          if ($urandom_range(0, (k >= 7) ? 30 : 7) == 0) joy[16*p+k] = ~joy[16*p+k];
      if ($urandom_range(0, 15) == 0) rot = 2'($urandom);
      if ($urandom_range(0, 40) == 0) cm = ~cm;
      if ($urandom_range(0, 20) == 0) af = 2'($urandom);
      step(joy, rot, cm, af, $urandom_range(0, 5) == 0, 1'($urandom), codes[$urandom_range(0, 15)]);
    end
    do_reset();
    idle(4, 32'h0, 1'b0, 2'b00);
    idle(5, 32'h0000_0100, 1'b1, 2'b00);
    do_reset();
    idle(4, 32'h0, 1'b0, 2'b00);
    for (int i = 0; i < 200; i++)
      step(32'($urandom) & 32'h01FF_01FF, 2'($urandom), 1'($urandom), 2'($urandom),
           $urandom_range(0, 3) == 0, 1'($urandom), codes[$urandom_range(0, 15)]);
    @(posedge clk_sys);
    #2;
    chk("drain", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
